// File: rtl/mux_rr_sequencer.sv
// -----------------------------------------------------------------------------
// mux_rr_sequencer
//
// Round-robin select sequencer placed in front of a 4:1 W-bit channel mux.
//
// Operation:
//   - Picks one of four requesters in round-robin order.
//   - Drives the mux select.
//   - Captures the mux output one cycle later.
//   - Presents the captured data downstream with a valid/ready handshake.
//   - Acknowledges the captured channel with a one-cycle ack pulse.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   req[3:0]   per-channel request level, bit i = channel i
//   ack[3:0]   one-cycle pulse on the bit of the captured channel
//   sel[1:0]   channel select driven to the 4:1 mux
//   mux_out    mux output (combinational function of sel)
//   out_data   captured channel data
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
//   busy       high whenever the sequencer is not idle
//   xfer_cnt   completed transfer count, wraps 255 -> 0
//
// Optional feature macro: MUX_RR_SEQ_CNT_EN
//   - Defined:   xfer_cnt counts completed handshakes.
//   - Undefined: the counter is absent and xfer_cnt is tied to zero.
// -----------------------------------------------------------------------------
module mux_rr_sequencer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    output logic [3:0]   ack,
    output logic [1:0]   sel,
    input  logic [W-1:0] mux_out,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic [7:0]   xfer_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [1:0]     sel_reg, sel_next;
    logic [1:0]     last_reg, last_next;
    logic [3:0]     ack_reg, ack_next;
    logic [W-1:0]   data_reg, data_next;
    logic           valid_reg, valid_next;

    // Candidate channels in search order: last+1, last+2, last+3, last+4.
    // The 2-bit addition provides the mod-4 wrap.
    logic [1:0]     cand [4];
    logic [1:0]     pick;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cand
            assign cand[gi] = last_reg + 2'(gi + 1);
        end
    endgenerate

    // Walk the candidates from the lowest priority to the highest.
    // The last match assigned is therefore the highest-priority requester.
    always_comb begin
        pick = cand[0];
        for (int k = 3; k >= 0; k--) begin
            if (req[cand[k]]) begin
                pick = cand[k];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        last_next  = last_reg;
        ack_next   = 4'b0000;
        data_next  = data_reg;
        valid_next = valid_reg;

        case (state_reg)
            IDLE: begin
                if (req != 4'b0000) begin
                    sel_next   = pick;
                    last_next  = pick;
                    state_next = CAPTURE;
                end
            end

            CAPTURE: begin
                // Capture and ack happen even if the request has dropped.
                data_next  = mux_out;
                valid_next = 1'b1;
                ack_next   = 4'b0001 << sel_reg;
                state_next = HOLD;
            end

            HOLD: begin
                if (out_ready) begin
                    valid_next = 1'b0;
                    if (req != 4'b0000) begin
                        sel_next   = pick;
                        last_next  = pick;
                        state_next = CAPTURE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sel_reg   <= 2'd0;
            last_reg  <= 2'd3;     // makes channel 0 the first pick after reset
            ack_reg   <= 4'b0000;
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            last_reg  <= last_next;
            ack_reg   <= ack_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
        end
    end

`ifdef MUX_RR_SEQ_CNT_EN
    logic       handshake;
    logic [7:0] cnt_reg;

    // Only HOLD presents valid data, so out_ready elsewhere is ignored.
    assign handshake = (state_reg == HOLD) && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= 8'd0;
        end else if (handshake) begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end

    assign xfer_cnt = cnt_reg;
`else
    assign xfer_cnt = 8'd0;
`endif

    assign sel       = sel_reg;
    assign ack       = ack_reg;
    assign out_data  = data_reg;
    assign out_valid = valid_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: doc/mux_rr_sequencer.md
Name: mux_rr_sequencer

Overview:
Round-robin select sequencer sitting directly upstream of the 4:1 W-bit channel mux. Arbitrates four requesters, drives the mux `sel`, captures the mux output one cycle later into a register, and presents it downstream with a valid/ready handshake. Acknowledges the granted requester with a one-cycle `ack` pulse.

Parameters:
W, 3, data width of the mux channels and of `mux_out`/`out_data`

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req  input  4  per-channel request, level, bit i = channel i
ack  output  4  one-cycle pulse on the bit of the captured channel
sel  output  2  channel select driven to the 4:1 mux
mux_out  input  W  mux output (combinational function of `sel`)
out_data  output  W  captured channel data
out_valid  output  1  `out_data` valid
out_ready  input  1  downstream accepts `out_data`
busy  output  1  high when state != IDLE
xfer_cnt  output  8  completed transfer count (optional feature)

Behaviour:
- Interface decision: one clock, `clk`. Reset `rst_n` is synchronous and active-low.
- Reset (`rst_n`=0 at a clk edge) has priority over everything and applies even mid-transfer:
  - state=IDLE, `sel`=0, `ack`=0, `out_data`=0, `out_valid`=0, `busy`=0, `xfer_cnt`=0, rr pointer `last`=2'd3.
- Round-robin pick: search order is `last`+1, +2, +3, +4 (mod 4). The first set bit of `req` wins, so after reset channel 0 has top priority.
- States:
  - IDLE: if `req`!=0, then `sel`<=pick, `last`<=pick, go to CAPTURE; otherwise stay. `sel` holds its last value.
  - CAPTURE (exactly 1 cycle, `sel` stable, `mux_out` settles):
    - `out_data`<=`mux_out`, `out_valid`<=1, `ack`[`sel`]<=1 (all other `ack` bits 0).
    - Go to HOLD.
    - Capture and ack happen even if `req`[`sel`] dropped meanwhile.
  - HOLD: `out_valid`=1 and `out_data`/`sel` are stable.
    - `ack` returns to 0 after its one cycle.
    - On an edge with `out_ready`=1 (handshake): `out_valid`<=0 and `xfer_cnt` increments. Then:
      - if `req`!=0: pick, `sel`<=pick, `last`<=pick, go to CAPTURE;
      - else go to IDLE.
    - With `out_ready`=0: stay in HOLD, nothing changes.
- Latency: `req` seen in IDLE at edge N gives `sel` updated after edge N, `out_valid` and `ack` high after edge N+1.
- Throughput: one transfer per 2 cycles with `out_ready` held at 1.
- `req` changes during CAPTURE/HOLD do not affect the current transfer. They are evaluated only at the next pick.
- `out_ready` is ignored while `out_valid`=0.
- `xfer_cnt` is 8-bit and wraps 255 -> 0.

Optional Feature:
MUX_RR_SEQ_CNT_EN
- Defined: `xfer_cnt` counts handshakes as specified above.
- Undefined: the counter logic is omitted and `xfer_cnt` is tied to 8'd0. The port is still present.

Test Plan:
1. After reset, `req`=4'b0001, mux model `mux_out`=`sel`-indexed {3'd5,3'd6,3'd7,3'd1}, `out_ready`=1:
   `sel`=0 one cycle after `req`; next cycle `out_data`=3'd5, `out_valid`=1, `ack`=4'b0001 for exactly 1 cycle.
2. `req`=4'b1111 held, `out_ready`=1:
   grant order 0,1,2,3,0,1, captured data 5,6,7,1,5,6, one `out_valid` beat every 2 cycles.
3. Backpressure: `out_ready`=0 for 5 cycles in HOLD:
   `out_valid` stays 1, `out_data` and `sel` stable, no further `ack`. Raising `out_ready` completes the transfer at that edge.
4. Last grant = channel 1, then `req`=4'b1001: grant 3 first, then 0. `req` dropped during CAPTURE still produces `ack` and data.
5. `rst_n`=0 for one edge while in HOLD with `out_valid`=1:
   after that edge all outputs are 0 and state is IDLE. Next `req`=4'b1111 grants channel 0.
6. Counter:
   - With MUX_RR_SEQ_CNT_EN, 256 handshakes: `xfer_cnt` goes 255 -> 0; stalled HOLD cycles do not count.
   - Without the macro: `xfer_cnt`=0 throughout.
